// File: rtl/transmission_map_estimator_p_if.sv
// Bundle of handshake, configuration and result signals of the
// transmission-map estimator.
//   master : upstream/window side (drives window, cfg, out_ready)
//   slave  : the estimator itself
// Signals:
//   win_i/in_valid/in_ready        3x3 window transfer
//   cfg_load/a_i/w_i/edge_th_i/mode_i  runtime configuration strobe + data
//   out_valid/out_ready            result transfer
//   tx_inv/dark_out/edge_out       result payload
interface transmission_map_estimator_p_if #(
  parameter int DATA_W = 8,
  parameter int CH     = 3,
  parameter int FRAC   = 8,
  parameter int TX_W   = 12
) ();
  logic [9*CH*DATA_W-1:0] win_i;
  logic                   in_valid;
  logic                   in_ready;
  logic                   cfg_load;
  logic [CH*DATA_W-1:0]   a_i;
  logic [4:0]             w_i;
  logic [DATA_W+2:0]      edge_th_i;
  logic                   mode_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [TX_W-1:0]        tx_inv;
  logic [DATA_W-1:0]      dark_out;
  logic                   edge_out;

  modport master (
    output win_i, in_valid, cfg_load, a_i, w_i, edge_th_i, mode_i, out_ready,
    input  in_ready, out_valid, tx_inv, dark_out, edge_out
  );

  modport slave (
    input  win_i, in_valid, cfg_load, a_i, w_i, edge_th_i, mode_i, out_ready,
    output in_ready, out_valid, tx_inv, dark_out, edge_out
  );
endinterface

// File: rtl/transmission_map_estimator_p.sv
// Transmission-map estimator: takes one 3x3 multi-channel window per
// transaction, classifies it as edge/flat with a per-channel Sobel magnitude,
// picks the edge-aware dark value and computes 1/t = (D<<FRAC)/num with a
// restoring divider (one quotient bit per cycle).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of transmission_map_estimator_p_if (window in,
//          configuration, result out; valid/ready on both sides)
module transmission_map_estimator_p #(
  parameter int DATA_W = 8,
  parameter int CH     = 3,
  parameter int FRAC   = 8,
  parameter int TX_W   = 12
) (
  input logic clk,
  input logic rst_n,
  transmission_map_estimator_p_if.slave bus
);
  localparam int ITER  = FRAC + 5;
  localparam int DW5   = DATA_W + 5;
  localparam int NW    = DW5 + FRAC;
  localparam int MAG_W = DATA_W + 3;
  localparam int WIN_W = 9 * CH * DATA_W;
  localparam int CNT_W = $clog2(ITER);
  localparam int QW    = (ITER > TX_W) ? ITER : TX_W;

  typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

  state_t state_q, state_d;

  // Configuration registers (live values, snapshotted at acceptance).
  logic [CH*DATA_W-1:0] a_cfg;
  logic [4:0]           w_cfg;
  logic [MAG_W-1:0]     th_cfg;
  logic                 mode_cfg;

  // Per-transaction snapshot and datapath state.
  logic [WIN_W-1:0]     win_q;
  logic [DATA_W-1:0]    a_min_q;
  logic [4:0]           w_q;
  logic [MAG_W-1:0]     th_q;
  logic                 is_edge_q, azero_q;
  logic [DATA_W-1:0]    dark_q;
  logic [DW5-1:0]       num_q, rem_q;
  logic [ITER-1:0]      quo_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [DATA_W-1:0]    a_min, centre_min, all_min, dark_c;
  logic                 is_edge_c;
  logic [DW5-1:0]       d_c, wd_c, floor_c, num_c;
  logic [NW-1:0]        dvd_c;
  logic [DW5:0]         trial;
  logic                 ge;
  logic [DW5-1:0]       rem_nxt;
  logic [ITER-1:0]      quo_nxt;
  logic [QW-1:0]        q_ext;
  logic [TX_W-1:0]      tx_c;
  logic                 div_last;

  function automatic logic [DATA_W-1:0] px(input logic [WIN_W-1:0] w,
                                           input int k, input int c);
    return w[(k*CH+c)*DATA_W +: DATA_W];
  endfunction

  // 1-2-1 weighted sum of three samples.
  function automatic logic [DATA_W+1:0] wsum(input logic [DATA_W-1:0] a, b, c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [DATA_W+1:0] absdiff(input logic [DATA_W+1:0] a, b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // |gx| + |gy| for one channel; each term is at most 4*max, so the sum
  // fits in DATA_W+3 bits.
  function automatic logic [MAG_W-1:0] sobel_mag(input logic [WIN_W-1:0] w,
                                                 input int c);
    logic [DATA_W+1:0] gx_p, gx_n, gy_p, gy_n;
    gx_p = wsum(px(w, 2, c), px(w, 5, c), px(w, 8, c));
    gx_n = wsum(px(w, 0, c), px(w, 3, c), px(w, 6, c));
    gy_p = wsum(px(w, 6, c), px(w, 7, c), px(w, 8, c));
    gy_n = wsum(px(w, 0, c), px(w, 1, c), px(w, 2, c));
    return {1'b0, absdiff(gx_p, gx_n)} + {1'b0, absdiff(gy_p, gy_n)};
  endfunction

  // Configuration capture; cfg_load is honoured in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources.
    if (!rst_n) begin
      a_cfg    <= '1;
      w_cfg    <= '0;
      th_cfg   <= '1;
      mode_cfg <= 1'b0;
    end else if (bus.cfg_load) begin
      a_cfg    <= bus.a_i;
      w_cfg    <= bus.w_i;
      th_cfg   <= bus.edge_th_i;
      mode_cfg <= bus.mode_i;
    end
  end

  // A_min from the live configuration; gray mode uses channel 0 only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    a_min = a_cfg[0 +: DATA_W];
    if (!mode_cfg) begin
      for (int c = 1; c < CH; c++) begin
        if (a_cfg[c*DATA_W +: DATA_W] < a_min) a_min = a_cfg[c*DATA_W +: DATA_W];
      end
    end
  end

  // Edge classification and dark value from the registered window.
  always_comb begin
    is_edge_c  = 1'b0;
    centre_min = '1;
    all_min    = '1;
    for (int c = 0; c < CH; c++) begin
      if (sobel_mag(win_q, c) > th_q) is_edge_c = 1'b1;
      if (px(win_q, 4, c) < centre_min) centre_min = px(win_q, 4, c);
      for (int k = 0; k < 9; k++) begin
        if (px(win_q, k, c) < all_min) all_min = px(win_q, k, c);
      end
    end
    dark_c = is_edge_c ? centre_min : all_min;
  end

  // Denominator with the t >= 1/16 floor.
  always_comb begin
    d_c     = {a_min_q, 5'b00000};
    wd_c    = DW5'(w_q) * DW5'(dark_c);
    floor_c = d_c >> 4;
    num_c   = d_c - wd_c;
    if ((wd_c >= d_c) || (num_c < floor_c)) num_c = floor_c;
    dvd_c   = NW'(d_c) << FRAC;
  end

  // One restoring-division step. The top NW-ITER dividend bits seed the
  // remainder; since q < 2^ITER they are always below num.
  always_comb begin
    trial    = {rem_q, quo_q[ITER-1]};
    ge       = trial >= {1'b0, num_q};
    rem_nxt  = ge ? DW5'(trial - {1'b0, num_q}) : trial[DW5-1:0];
    quo_nxt  = {quo_q[ITER-2:0], ge};
    q_ext    = QW'(quo_nxt);
    div_last = (cnt_q == CNT_W'(ITER - 1));
    if (azero_q)                          tx_c = TX_W'(1) << FRAC;
    else if (q_ext > QW'({TX_W{1'b1}}))   tx_c = '1;
    else                                  tx_c = q_ext[TX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid)  state_d = CALC;
      CALC:                    state_d = DIV;
      DIV:  if (div_last)      state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the window and snapshot registers are reset as well, so an
    // aborted transaction leaves no stale operand behind.
    if (!rst_n) begin
      win_q        <= '0;
      a_min_q      <= '0;
      w_q          <= '0;
      th_q         <= '0;
      is_edge_q    <= 1'b0;
      azero_q      <= 1'b0;
      dark_q       <= '0;
      num_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      bus.tx_inv   <= '0;
      bus.dark_out <= '0;
      bus.edge_out <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          win_q   <= bus.win_i;
          a_min_q <= a_min;
          w_q     <= w_cfg;
          th_q    <= th_cfg;
        end
        CALC: begin
          is_edge_q <= is_edge_c;
          dark_q    <= dark_c;
          num_q     <= num_c;
          azero_q   <= (a_min_q == '0);
          rem_q     <= dvd_c[NW-1:ITER];
          quo_q     <= dvd_c[ITER-1:0];
          cnt_q     <= '0;
        end
        DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          // Result registers load with the final quotient bit included.
          if (div_last) begin
            bus.tx_inv   <= tx_c;
            bus.dark_out <= dark_q;
            bus.edge_out <= is_edge_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
